out_port_buffer: RTL and testbench

Output-port stage downstream of the CPU datapath. Captures the value the datapath drives onto its bus during an `out` instruction (`out_port_enable` asserted with `R[Gra]` on the bus) into a small FIFO. Presents the words to an external consumer over a valid/ready handshake, so a slow device never stalls the datapath. It also keeps a mirror of the last accepted word for display/debug.

---
 rtl/out_port_pkg.sv | 14 +
 rtl/out_port_fifo.sv | 59 +++++
 rtl/out_port_buffer.sv | 85 ++++++++
 tb/tb_out_port_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared constants and width helpers for the output-port buffer.
package out_port_pkg;

  localparam int OUT_PORT_WIDTH = 32;
  localparam int OUT_PORT_DEPTH = 4;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(OUT_PORT_DEPTH):0] count_t;

endpackage

// File: rtl/out_port_fifo.sv
// Small power-of-two FIFO with separate occupancy counter.
// A write while full is accepted only when a pop happens in the same cycle.
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int WIDTH = OUT_PORT_WIDTH,
  parameter int DEPTH = OUT_PORT_DEPTH
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic                      accepted,
  output logic                      dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             rd_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign rd_ok    = rd & ~empty;
  assign accepted = wr & (~full | rd_ok);
  assign dropped  = wr & full & ~rd_ok;
  assign rdata    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!clr && accepted) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accepted) wptr <= wptr + PTR_W'(1);
      if (rd_ok)    rptr <= rptr + PTR_W'(1);
      case ({accepted, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_buffer.sv
// Output-port stage: edge-detected datapath strobe into a FIFO drained over valid/ready.
// Define OUT_PORT_PARITY_EN to carry an even-parity bit alongside each word (ext_parity).
module out_port_buffer
  import out_port_pkg::*;
#(
  parameter int WIDTH = OUT_PORT_WIDTH,
  parameter int DEPTH = OUT_PORT_DEPTH
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      out_port_enable,
  input  logic [WIDTH-1:0]          bus_data,
  output logic [WIDTH-1:0]          out_port_data_out,
  output logic [WIDTH-1:0]          ext_data,
  output logic                      ext_valid,
  input  logic                      ext_ready,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      overflow
`ifdef OUT_PORT_PARITY_EN
  ,
  output logic                      ext_parity
`endif
);

`ifdef OUT_PORT_PARITY_EN
  localparam int STORE_W = WIDTH + 1;
`else
  localparam int STORE_W = WIDTH;
`endif

  logic               en_q;
  logic               wr;
  logic               rd;
  logic               empty;
  logic               accepted;
  logic               dropped;
  logic [STORE_W-1:0] store_in;
  logic [STORE_W-1:0] store_out;

  // One write per strobe assertion, however long the datapath holds it.
  assign wr = out_port_enable & ~en_q;
  assign rd = ext_valid & ext_ready;

`ifdef OUT_PORT_PARITY_EN
  assign store_in   = {^bus_data, bus_data};
  assign ext_data   = store_out[WIDTH-1:0];
  assign ext_parity = store_out[WIDTH] & ext_valid;
`else
  assign store_in   = bus_data;
  assign ext_data   = store_out;
`endif

  assign ext_valid = ~empty;

  out_port_fifo #(
    .WIDTH (STORE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .wr       (wr),
    .rd       (rd),
    .wdata    (store_in),
    .rdata    (store_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .accepted (accepted),
    .dropped  (dropped)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      en_q              <= 1'b0;
      out_port_data_out <= '0;
      overflow          <= 1'b0;
    end else begin
      en_q <= out_port_enable;
      if (accepted) out_port_data_out <= bus_data;
      if (dropped)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed plus randomized bench for out_port_buffer against a queue-based reference model.
module tb_out_port_buffer;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          clr;
  logic          out_port_enable;
  logic [W-1:0]  bus_data;
  logic [W-1:0]  out_port_data_out;
  logic [W-1:0]  ext_data;
  logic          ext_valid;
  logic          ext_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
`ifdef OUT_PORT_PARITY_EN
  logic          ext_parity;
`endif

  out_port_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk               (clk),
    .clr               (clr),
    .out_port_enable   (out_port_enable),
    .bus_data          (bus_data),
    .out_port_data_out (out_port_data_out),
    .ext_data          (ext_data),
    .ext_valid         (ext_valid),
    .ext_ready         (ext_ready),
    .count             (count),
    .full              (full),
    .overflow          (overflow)
`ifdef OUT_PORT_PARITY_EN
    ,
    .ext_parity        (ext_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue contents, mirror, sticky overflow, previous strobe level.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_mirror = '0;
  logic         m_ovf    = 1'b0;
  logic         m_prev   = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_step(input logic c, input logic e, input logic r, input logic [W-1:0] d);
    bit new_strobe;
    bit pop;
    if (c) begin
      mq.delete();
      m_mirror = '0;
      m_ovf    = 1'b0;
      m_prev   = 1'b0;
    end else begin
      new_strobe = e && !m_prev;
      pop        = (mq.size() != 0) && r;
      if (pop) void'(mq.pop_front());
      if (new_strobe) begin
        if (mq.size() < D) begin
          mq.push_back(d);
          m_mirror = d;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev = e;
    end
  endtask

  task automatic check_all();
    chk("count", W'(count), W'(mq.size()));
    chk("ext_valid", W'(ext_valid), W'(mq.size() != 0));
    chk("full", W'(full), W'(mq.size() == D));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("mirror", out_port_data_out, m_mirror);
    if (mq.size() != 0) begin
      chk("ext_data", ext_data, mq[0]);
`ifdef OUT_PORT_PARITY_EN
      chk("ext_parity", W'(ext_parity), W'(^mq[0]));
`endif
    end
  endtask

  task automatic cycle(input logic c, input logic e, input logic r, input logic [W-1:0] d);
    clr = c; out_port_enable = e; ext_ready = r; bus_data = d;
    model_step(c, e, r, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    clr = 1'b1; out_port_enable = 1'b0; ext_ready = 1'b0; bus_data = '0;

    // Reset then idle
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("rst_count", W'(count), 0);
    chk("rst_valid", W'(ext_valid), 0);
    chk("rst_mirror", out_port_data_out, 0);
    chk("rst_ovf", W'(overflow), 0);
`ifdef OUT_PORT_PARITY_EN
    chk("rst_parity", W'(ext_parity), 0);
`endif

    // Held strobe writes exactly once
    cycle(0, 1, 0, 32'h0000_00A5);
    chk("held_data_n1", ext_data, 32'h0000_00A5);
    cycle(0, 1, 0, 32'h0000_00A5);
    cycle(0, 1, 0, 32'h0000_00A5);
    chk("held_count", W'(count), 1);
    chk("held_mirror", out_port_data_out, 32'h0000_00A5);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Fill and overflow
    for (int v = 1; v <= 5; v++) begin
      cycle(0, 1, 0, W'(v));
      cycle(0, 0, 0, 0);
    end
    chk("fill_full", W'(full), 1);
    chk("fill_ovf", W'(overflow), 1);
    chk("fill_mirror", out_port_data_out, 4);
    for (int k = 1; k <= 4; k++) begin
      chk("fill_pop", ext_data, W'(k));
      cycle(0, 0, 1, 0);
    end
    chk("fill_drained", W'(ext_valid), 0);

    // Full with simultaneous write and pop
    cycle(1, 0, 0, 0);
    for (int v = 1; v <= 4; v++) begin
      cycle(0, 1, 0, W'(v));
      cycle(0, 0, 0, 0);
    end
    cycle(0, 1, 1, 9);
    chk("fullrw_ovf", W'(overflow), 0);
    chk("fullrw_count", W'(count), 4);
    begin
      logic [W-1:0] order [4];
      order = '{2, 3, 4, 9};
      for (int k = 0; k < 4; k++) begin
        chk("fullrw_pop", ext_data, order[k]);
        cycle(0, 0, 1, 0);
      end
    end

    // Wrap-around through all pointer values
    for (int v = 'h10; v <= 'h19; v++) begin
      cycle(0, 1, 1, W'(v));
      chk("wrap_data", ext_data, W'(v));
      chk("wrap_count_le1", W'(count <= 1), 1);
      cycle(0, 0, 1, 0);
    end

    // Reset mid-operation with strobe rising in the reset cycle
    for (int v = 0; v < 3; v++) begin
      cycle(0, 1, 0, W'(32'hC0 + v));
      cycle(0, 0, 0, 0);
    end
    cycle(1, 1, 0, 32'h0000_00BB);
    cycle(0, 0, 0, 0);
    chk("midrst_count", W'(count), 0);
    chk("midrst_valid", W'(ext_valid), 0);

`ifdef OUT_PORT_PARITY_EN
    cycle(0, 1, 0, 32'h0000_0007);
    chk("parity_7", W'(ext_parity), 1);
    cycle(0, 0, 1, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
